// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch-side request controller for the RV32I pipelined core. Owns the fetch
//   PC, issues ready/valid requests to IMEM and keeps every in-flight request
//   in an in-order ring buffer. Returning instructions are paired with their
//   PC and PC+4 and handed to the fetch/decode pipe. A redirect kills every
//   outstanding entry; killed entries drain silently once their response lands.
//
// Ports
//   clk, async_rst_n        clock, asynchronous active-low reset
//   redirect_valid_in/_pc_in redirect from execute
//   imem_pc_out/_valid_out, imem_pc_ready_in          request channel
//   imem_instr_in/_valid_in, imem_instr_ready_out     response channel
//   instr_out, pc_out, pc_plus_4_out,
//   instr_valid_out, instr_ready_in                   toward FD pipe
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int unsigned           PC_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  redirect_valid_in,
  input  logic [PC_WIDTH-1:0]   redirect_pc_in,
  output logic [PC_WIDTH-1:0]   imem_pc_out,
  output logic                  imem_pc_valid_out,
  input  logic                  imem_pc_ready_in,
  input  logic [DATA_WIDTH-1:0] imem_instr_in,
  input  logic                  imem_instr_valid_in,
  output logic                  imem_instr_ready_out,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   pc_plus_4_out,
  output logic                  instr_valid_out,
  input  logic                  instr_ready_in
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Ring buffer storage
  logic [PC_WIDTH-1:0]   ent_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] ent_instr [DEPTH];
  logic [DEPTH-1:0]      ent_filled;
  logic [DEPTH-1:0]      ent_killed;

  logic [PTR_W-1:0]      head_ptr;   // oldest entry
  logic [PTR_W-1:0]      tail_ptr;   // next entry to allocate
  logic [PTR_W-1:0]      fill_ptr;   // oldest unfilled entry
  logic [CNT_W-1:0]      occ_cnt;    // allocated entries
  logic [CNT_W-1:0]      pend_cnt;   // allocated but not yet filled
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  run_q;      // low until the first edge after reset release

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  out_fire;
  logic                  drain;
  logic                  pop;
  logic                  head_filled;
  logic                  head_killed;
  logic [DEPTH-1:0]      alloc_mask;
  logic [PTR_W-1:0]      offset;

  // ---------------------------------------------------------------------------
  // Combinational handshakes and outputs
  // ---------------------------------------------------------------------------
  assign head_filled = ent_filled[head_ptr];
  assign head_killed = ent_killed[head_ptr];

  // Depends only on state and redirect, never on instr_ready_in.
  assign imem_pc_valid_out    = run_q & (occ_cnt < DEPTH_C) & ~redirect_valid_in;
  assign imem_pc_out          = fetch_pc;
  assign imem_instr_ready_out = run_q;

  assign instr_valid_out = head_filled & ~head_killed & ~redirect_valid_in;
  assign instr_out       = ent_instr[head_ptr];
  assign pc_out          = ent_pc[head_ptr];
  assign pc_plus_4_out   = pc_out + PC_WIDTH'(4);

  assign req_fire = imem_pc_valid_out & imem_pc_ready_in;
  // A response with nothing outstanding is ignored.
  assign rsp_fire = imem_instr_valid_in & run_q & (pend_cnt != '0);
  assign out_fire = instr_valid_out & instr_ready_in;
  // Filled-but-killed head leaves without producing output.
  assign drain    = head_filled & head_killed;
  assign pop      = out_fire | drain;

  // Entries currently allocated: offset from head below occupancy.
  always_comb begin
    alloc_mask = '0;
    offset     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - head_ptr;
      alloc_mask[i] = (CNT_W'(offset) < occ_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      run_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      occ_cnt  <= '0;
      pend_cnt <= '0;
    end else begin
      run_q <= 1'b1;

      if (redirect_valid_in)
        fetch_pc <= redirect_pc_in;
      else if (req_fire)
        fetch_pc <= fetch_pc + PC_WIDTH'(4);

      if (req_fire) tail_ptr <= tail_ptr + PTR_W'(1);
      if (rsp_fire) fill_ptr <= fill_ptr + PTR_W'(1);
      if (pop)      head_ptr <= head_ptr + PTR_W'(1);

      case ({req_fire, pop})
        2'b10:   occ_cnt <= occ_cnt + CNT_W'(1);
        2'b01:   occ_cnt <= occ_cnt - CNT_W'(1);
        default: occ_cnt <= occ_cnt;
      endcase

      case ({req_fire, rsp_fire})
        2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry state. Index collisions between allocate/fill/pop cannot occur
  // (allocate needs occ < DEPTH, fill targets unfilled, pop targets filled);
  // pop is written last so a draining head is cleared even during a redirect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      ent_filled <= '0;
      ent_killed <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[i]    <= '0;
        ent_instr[i] <= '0;
      end
    end else begin
      if (redirect_valid_in)
        ent_killed <= ent_killed | alloc_mask;

      if (req_fire) begin
        ent_pc[tail_ptr]     <= fetch_pc;
        ent_filled[tail_ptr] <= 1'b0;
        ent_killed[tail_ptr] <= 1'b0;
      end

      // Data written even into a killed entry; it is never presented.
      if (rsp_fire) begin
        ent_instr[fill_ptr]  <= imem_instr_in;
        ent_filled[fill_ptr] <= 1'b1;
      end

      if (pop) begin
        ent_filled[head_ptr] <= 1'b0;
        ent_killed[head_ptr] <= 1'b0;
      end
    end
  end

  // Response without an outstanding request is a protocol violation.
  rsp_credit_chk: assert property (@(posedge clk) disable iff (!async_rst_n)
    (imem_instr_valid_in && run_q) |-> (pend_cnt != '0));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        async_rst_n;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] imem_pc_out;
  logic        imem_pc_valid_out;
  logic        imem_pc_ready_in;
  logic [31:0] imem_instr_in;
  logic        imem_instr_valid_in;
  logic        imem_instr_ready_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_4_out;
  logic        instr_valid_out;
  logic        instr_ready_in;

  int vec_cnt;
  int err_cnt;
  int fire_cnt;
  logic auto_imem;

  imem_fetch_ctrl #(
    .PC_WIDTH  (32),
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .async_rst_n         (async_rst_n),
    .redirect_valid_in   (redirect_valid_in),
    .redirect_pc_in      (redirect_pc_in),
    .imem_pc_out         (imem_pc_out),
    .imem_pc_valid_out   (imem_pc_valid_out),
    .imem_pc_ready_in    (imem_pc_ready_in),
    .imem_instr_in       (imem_instr_in),
    .imem_instr_valid_in (imem_instr_valid_in),
    .imem_instr_ready_out(imem_instr_ready_out),
    .instr_out           (instr_out),
    .pc_out              (pc_out),
    .pc_plus_4_out       (pc_plus_4_out),
    .instr_valid_out     (instr_valid_out),
    .instr_ready_in      (instr_ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Instruction word the IMEM model returns for a given address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
  endfunction

  // One clock: sample the request handshake before the edge, then act as a
  // 1-cycle-latency IMEM by answering in the following cycle.
  task automatic cyc();
    logic        f;
    logic [31:0] a;
    #1;
    f = imem_pc_valid_out & imem_pc_ready_in;
    a = imem_pc_out;
    if (f) fire_cnt++;
    @(posedge clk);
    #1;
    if (auto_imem) begin
      imem_instr_valid_in = f;
      imem_instr_in       = f ? instr_of(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    auto_imem           = 1'b0;
    imem_instr_valid_in = 1'b0;
    imem_instr_in       = '0;
    redirect_valid_in   = 1'b0;
    redirect_pc_in      = '0;
    imem_pc_ready_in    = 1'b0;
    instr_ready_in      = 1'b0;
    async_rst_n         = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    auto_imem = 1'b0; imem_instr_valid_in = 1'b0; redirect_valid_in = 1'b0;
    redirect_pc_in = '0; imem_pc_ready_in = 1'b0; instr_ready_in = 1'b0;
    imem_instr_in = '0;
    async_rst_n = 1'b0;
    @(posedge clk); #2;
    vec_cnt++; if (imem_pc_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rst_req_valid got=%b exp=0", imem_pc_valid_out); end
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid_out); end
    vec_cnt++; if (imem_instr_ready_out !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_ready got=%b exp=0", imem_instr_ready_out); end
    async_rst_n = 1'b1;
    cyc();
    #1;
    vec_cnt++; if (imem_pc_valid_out !== 1'b1) begin err_cnt++; $display("FAIL rel_req_valid got=%b exp=1", imem_pc_valid_out); end
    vec_cnt++; if (imem_pc_out !== 32'h0) begin err_cnt++; $display("FAIL rel_req_pc got=%h exp=00000000", imem_pc_out); end
    vec_cnt++; if (imem_instr_ready_out !== 1'b1) begin err_cnt++; $display("FAIL rel_rsp_ready got=%b exp=1", imem_instr_ready_out); end
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rel_instr_valid got=%b exp=0", instr_valid_out); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b1; auto_imem = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      vec_cnt++; if (imem_pc_valid_out !== 1'b1) begin err_cnt++; $display("FAIL stream_req_valid k=%0d got=%b exp=1", k, imem_pc_valid_out); end
      vec_cnt++; if (imem_pc_out !== 32'(4 * k)) begin err_cnt++; $display("FAIL stream_req_pc k=%0d got=%h exp=%h", k, imem_pc_out, 32'(4 * k)); end
      if (k >= 2) begin
        vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL stream_out_valid k=%0d got=%b exp=1", k, instr_valid_out); end
        vec_cnt++; if (pc_out !== 32'(4 * (k - 2))) begin err_cnt++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, pc_out, 32'(4 * (k - 2))); end
        vec_cnt++; if (pc_plus_4_out !== 32'(4 * (k - 1))) begin err_cnt++; $display("FAIL stream_pc4 k=%0d got=%h exp=%h", k, pc_plus_4_out, 32'(4 * (k - 1))); end
        vec_cnt++; if (instr_out !== instr_of(32'(4 * (k - 2)))) begin err_cnt++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, instr_out, instr_of(32'(4 * (k - 2)))); end
      end else begin
        vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL stream_early_valid k=%0d got=%b exp=0", k, instr_valid_out); end
      end
      cyc();
    end
  endtask

  task automatic test_full();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b0; auto_imem = 1'b1;
    fire_cnt = 0;
    for (int i = 0; i < 8; i++) cyc();
    #1;
    vec_cnt++; if (fire_cnt !== 4) begin err_cnt++; $display("FAIL full_accepted got=%0d exp=4", fire_cnt); end
    vec_cnt++; if (imem_pc_valid_out !== 1'b0) begin err_cnt++; $display("FAIL full_req_valid got=%b exp=0", imem_pc_valid_out); end
    vec_cnt++; if (imem_pc_out !== 32'h10) begin err_cnt++; $display("FAIL full_req_pc got=%h exp=00000010", imem_pc_out); end
    instr_ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL full_out_valid k=%0d got=%b exp=1", k, instr_valid_out); end
      vec_cnt++; if (pc_out !== 32'(4 * k)) begin err_cnt++; $display("FAIL full_pc k=%0d got=%h exp=%h", k, pc_out, 32'(4 * k)); end
      vec_cnt++; if (instr_out !== instr_of(32'(4 * k))) begin err_cnt++; $display("FAIL full_instr k=%0d got=%h exp=%h", k, instr_out, instr_of(32'(4 * k))); end
      cyc();
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b1; auto_imem = 1'b1;
    cyc(); cyc();
    imem_pc_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++; if (imem_pc_valid_out !== 1'b1) begin err_cnt++; $display("FAIL stall_valid i=%0d got=%b exp=1", i, imem_pc_valid_out); end
      vec_cnt++; if (imem_pc_out !== 32'h8) begin err_cnt++; $display("FAIL stall_pc i=%0d got=%h exp=00000008", i, imem_pc_out); end
      cyc();
    end
    imem_pc_ready_in = 1'b1;
    #1;
    vec_cnt++; if (imem_pc_out !== 32'h8) begin err_cnt++; $display("FAIL stall_release_pc got=%h exp=00000008", imem_pc_out); end
    cyc();
    #1;
    vec_cnt++; if (imem_pc_out !== 32'hC) begin err_cnt++; $display("FAIL stall_after_pc got=%h exp=0000000c", imem_pc_out); end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b1; auto_imem = 1'b0;
    cyc(); cyc();                         // requests 0x0 and 0x4 in flight
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h100;
    #1;
    vec_cnt++; if (imem_pc_valid_out !== 1'b0) begin err_cnt++; $display("FAIL redir_withdraw got=%b exp=0", imem_pc_valid_out); end
    cyc();
    redirect_valid_in = 1'b0;
    imem_instr_valid_in = 1'b1; imem_instr_in = 32'hDEAD_0000;   // stale for 0x0
    #1;
    vec_cnt++; if (imem_pc_out !== 32'h100) begin err_cnt++; $display("FAIL redir_req_pc got=%h exp=00000100", imem_pc_out); end
    vec_cnt++; if (imem_pc_valid_out !== 1'b1) begin err_cnt++; $display("FAIL redir_req_valid got=%b exp=1", imem_pc_valid_out); end
    cyc();
    imem_instr_in = 32'hDEAD_0004;                                 // stale for 0x4
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL redir_stale0 got=%b exp=0", instr_valid_out); end
    cyc();
    imem_instr_in = instr_of(32'h100);                             // response for 0x100
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL redir_stale1 got=%b exp=0", instr_valid_out); end
    cyc();
    imem_instr_valid_in = 1'b0;
    imem_pc_ready_in = 1'b0;
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL redir_first_valid got=%b exp=1", instr_valid_out); end
    vec_cnt++; if (pc_out !== 32'h100) begin err_cnt++; $display("FAIL redir_first_pc got=%h exp=00000100", pc_out); end
    vec_cnt++; if (pc_plus_4_out !== 32'h104) begin err_cnt++; $display("FAIL redir_first_pc4 got=%h exp=00000104", pc_plus_4_out); end
    vec_cnt++; if (instr_out !== instr_of(32'h100)) begin err_cnt++; $display("FAIL redir_first_instr got=%h exp=%h", instr_out, instr_of(32'h100)); end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b1; auto_imem = 1'b1;
    cyc(); cyc();                         // 0x0 filled, response for 0x4 now on the bus
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL rr_pre_valid got=%b exp=1", instr_valid_out); end
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h200;
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rr_redir_valid got=%b exp=0", instr_valid_out); end
    cyc();
    redirect_valid_in = 1'b0;
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rr_drain0 got=%b exp=0", instr_valid_out); end
    vec_cnt++; if (imem_pc_out !== 32'h200) begin err_cnt++; $display("FAIL rr_req_pc got=%h exp=00000200", imem_pc_out); end
    cyc();
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL rr_drain1 got=%b exp=0", instr_valid_out); end
    cyc();
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL rr_post_valid got=%b exp=1", instr_valid_out); end
    vec_cnt++; if (pc_out !== 32'h200) begin err_cnt++; $display("FAIL rr_post_pc got=%h exp=00000200", pc_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b1; auto_imem = 1'b1;
    redirect_valid_in = 1'b1; redirect_pc_in = 32'h300;
    cyc();
    redirect_pc_in = 32'hFFFF_FFFC;
    cyc();
    redirect_valid_in = 1'b0;
    #1;
    vec_cnt++; if (imem_pc_out !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL b2b_req_pc got=%h exp=fffffffc", imem_pc_out); end
    cyc();
    #1;
    vec_cnt++; if (imem_pc_out !== 32'h0) begin err_cnt++; $display("FAIL b2b_wrap_pc got=%h exp=00000000", imem_pc_out); end
    cyc();
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid got=%b exp=1", instr_valid_out); end
    vec_cnt++; if (pc_out !== 32'hFFFF_FFFC) begin err_cnt++; $display("FAIL b2b_pc got=%h exp=fffffffc", pc_out); end
    vec_cnt++; if (pc_plus_4_out !== 32'h0) begin err_cnt++; $display("FAIL b2b_pc4 got=%h exp=00000000", pc_plus_4_out); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    imem_pc_ready_in = 1'b1; instr_ready_in = 1'b0; auto_imem = 1'b1;
    cyc(); cyc(); cyc();                  // 3 entries occupied
    #1;
    vec_cnt++; if (instr_valid_out !== 1'b1) begin err_cnt++; $display("FAIL mr_pre_valid got=%b exp=1", instr_valid_out); end
    auto_imem = 1'b0; imem_instr_valid_in = 1'b0;
    async_rst_n = 1'b0;
    #1;
    vec_cnt++; if (imem_pc_valid_out !== 1'b0) begin err_cnt++; $display("FAIL mr_req_valid got=%b exp=0", imem_pc_valid_out); end
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL mr_instr_valid got=%b exp=0", instr_valid_out); end
    vec_cnt++; if (imem_instr_ready_out !== 1'b0) begin err_cnt++; $display("FAIL mr_rsp_ready got=%b exp=0", imem_instr_ready_out); end
    @(posedge clk); #1;
    async_rst_n = 1'b1;
    cyc();
    #1;
    vec_cnt++; if (imem_pc_valid_out !== 1'b1) begin err_cnt++; $display("FAIL mr_rel_valid got=%b exp=1", imem_pc_valid_out); end
    vec_cnt++; if (imem_pc_out !== 32'h0) begin err_cnt++; $display("FAIL mr_rel_pc got=%h exp=00000000", imem_pc_out); end
    vec_cnt++; if (instr_valid_out !== 1'b0) begin err_cnt++; $display("FAIL mr_rel_instr_valid got=%b exp=0", instr_valid_out); end
  endtask

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    fire_cnt = 0;
    test_reset();
    test_stream();
    test_full();
    test_req_stall();
    test_redirect();
    test_redirect_rsp();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
